// File: rtl/writeback_regfile.sv
// Purpose: MEM/WB writeback register file (r1..r31, r0 hardwired to 0) with bypassed reads, debug port and commit tracking.
// Latency: qa/qb/wb_data combinational (same-cycle write-through); dbg_q, last_* and counters registered, 1 cycle.
// Backpressure: none; a write is accepted on every edge, and reset discards it.
module writeback_regfile #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [4:0]        wrn,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wdo,
  input  logic [4:0]        rna,
  input  logic [4:0]        rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  input  logic [4:0]        dbg_rn,
  output logic [DATA_W-1:0] dbg_q,
  output logic [DATA_W-1:0] wb_data,
  output logic              last_valid,
  output logic [4:0]        last_rn,
  output logic [DATA_W-1:0] last_data,
  output logic [31:0]       retire_cnt,
  output logic [15:0]       zero_wr_cnt
);

  // r0 is never stored; index 0 is guarded on every read path.
  logic [DATA_W-1:0] regs [1:31];

  logic              commit;
  logic              zero_wr;
  logic              byp_ok;
  logic [DATA_W-1:0] dbg_next;

  assign wb_data = wm2reg ? wdo : wr;
  assign commit  = wwreg && (wrn != 5'd0) && !rst;
  assign zero_wr = wwreg && (wrn == 5'd0) && !rst;
  // While reset is held the write is dead, so reads show stored contents only.
  assign byp_ok  = wwreg && !rst;

  // Read port A: r0 reads zero, same-cycle write to rna is forwarded.
  always_comb begin
    qa = '0;
    if (rna != 5'd0) begin
      if (byp_ok && (wrn == rna)) qa = wb_data;
      else                        qa = regs[rna];
    end
  end

  // Read port B: identical rule to port A so rna==rnb always agrees.
  always_comb begin
    qb = '0;
    if (rnb != 5'd0) begin
      if (byp_ok && (wrn == rnb)) qb = wb_data;
      else                        qb = regs[rnb];
    end
  end

  // Debug read value as a bypassed read would see it at this edge.
  always_comb begin
    dbg_next = '0;
    if (dbg_rn != 5'd0) begin
      if (byp_ok && (wrn == dbg_rn)) dbg_next = wb_data;
      else                           dbg_next = regs[dbg_rn];
    end
  end

  // Register storage: reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= RESET_VAL;
    end else if (commit) begin
      regs[wrn] <= wb_data;
    end
  end

  // Debug output register, one cycle behind dbg_rn.
  always_ff @(posedge clk) begin
    if (rst) dbg_q <= '0;
    else     dbg_q <= dbg_next;
  end

  // Last-commit tracking: valid pulses per commit, rn/data hold between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_rn    <= 5'd0;
      last_data  <= '0;
    end else begin
      last_valid <= commit;
      if (commit) begin
        last_rn   <= wrn;
        last_data <= wb_data;
      end
    end
  end

  // Retire counter wraps naturally; r0-write counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt  <= 32'd0;
      zero_wr_cnt <= 16'd0;
    end else begin
      if (commit) retire_cnt <= retire_cnt + 32'd1;
      if (zero_wr && (zero_wr_cnt != 16'hFFFF)) zero_wr_cnt <= zero_wr_cnt + 16'd1;
    end
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter: DATA_W, 32, width of every register and data port.
REQ-002 Parameter: RESET_VAL, 32'h0000_0000, value loaded into registers r1..r31 on reset.
REQ-003 Port: clk  in  1  system clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: wwreg  in  1  writeback enable from MEM/WB stage.
REQ-006 Port: wm2reg  in  1  writeback source select: 1 = wdo (memory data), 0 = wr (ALU result).
REQ-007 Port: wrn  in  5  destination register number.
REQ-008 Port: wr  in  DATA_W  ALU result from MEM/WB.
REQ-009 Port: wdo  in  DATA_W  memory load data from MEM/WB.
REQ-010 Port: rna, rnb  in  5 each  decode-stage read addresses, ports A and B.
REQ-011 Port: qa, qb  out  DATA_W each  read data for ports A and B (combinational).
REQ-012 Port: dbg_rn  in  5  debug read address.
REQ-013 Port: dbg_q  out  DATA_W  debug read data, registered.
REQ-014 Port: wb_data  out  DATA_W  combinational writeback value, = wm2reg ? wdo : wr.
REQ-015 Port: last_valid  out  1  registered; a committed write occurred last cycle.
REQ-016 Port: last_rn  out  5  registered; destination of the last committed write.
REQ-017 Port: last_data  out  DATA_W  registered; value of the last committed write.
REQ-018 Port: retire_cnt  out  32  count of committed writes.
REQ-019 Port: zero_wr_cnt  out  16  count of discarded writes to r0.

Function
REQ-020 Storage: 31 registers r1..r31; r0 is not stored and reads as 0 on every port.
REQ-021 Commit condition: wwreg=1, wrn!=0 and rst=0; on the rising edge, register[wrn] <= wb_data.
REQ-022 A write with wwreg=1 and wrn=0 does not modify storage and increments zero_wr_cnt. zero_wr_cnt saturates at 16'hFFFF.
REQ-023 Each commit increments retire_cnt by 1. retire_cnt wraps from 32'hFFFF_FFFF to 0.
REQ-024 Read ports A and B are combinational with write-through bypass: if rnX!=0, wwreg=1 and wrn==rnX, then qX = wb_data in the same cycle; otherwise qX = register[rnX].
REQ-025 rna==rnb is legal; both ports return identical data, including under bypass.
REQ-026 dbg_q updates one cycle after dbg_rn is presented (1-cycle latency), with dbg_q <= value seen by a bypassed read of dbg_rn at that edge. Same bypass rule as REQ-024; dbg_rn=0 yields 0.
REQ-027 last_valid, last_rn and last_data are updated every edge:
- last_valid <= commit condition.
- On commit: last_rn <= wrn, last_data <= wb_data.
- Otherwise last_rn and last_data hold their values.
REQ-028 wm2reg is don't-care when wwreg=0; no state changes when wwreg=0.
REQ-029 X on wr or wdo with wwreg=0 shall not propagate into storage or counters.

Reset
REQ-030 When rst=1 at a rising edge:
- r1..r31 <= RESET_VAL.
- dbg_q, last_data <= 0; last_rn <= 0; last_valid <= 0.
- retire_cnt <= 0; zero_wr_cnt <= 0.
REQ-031 rst has priority over a simultaneous write: a write presented in the reset cycle is discarded and counts nowhere.
REQ-032 During rst=1, qa/qb return the stored (pre-reset) contents without bypass. From the first edge with rst=1 they return RESET_VAL.
REQ-033 Reset asserted mid-stream (between back-to-back writes) leaves no partial state; the first post-reset write behaves as from power-up.

Verification
REQ-034 Scenario ALU write: rst 1 cycle; wwreg=1, wm2reg=0, wrn=5, wr=32'h1234_5678 for 1 edge; next cycle rna=5 -> qa=32'h1234_5678, last_valid=1, last_rn=5, retire_cnt=1.
REQ-035 Scenario load write with bypass: wwreg=1, wm2reg=1, wrn=9, wdo=32'hDEAD_BEEF, rna=rnb=9 in the same cycle -> qa=qb=32'hDEAD_BEEF before the edge; register 9 holds it after.
REQ-036 Scenario r0 discard: wwreg=1, wrn=0, wr=32'hFFFF_FFFF -> qa (rna=0)=0, bypass not applied, retire_cnt unchanged, zero_wr_cnt +1, last_valid=0.
REQ-037 Scenario write/reset collision: rst=1 with wwreg=1, wrn=3, wr=32'h55 -> after the edge r3=RESET_VAL, retire_cnt=0, last_valid=0.
REQ-038 Scenario debug port and back-to-back writes:
- Writes r7=1, r7=2, r8=3 on consecutive edges -> retire_cnt=3.
- dbg_rn=7 -> dbg_q=2 one cycle later; r8=3.
- last_rn=8, last_data=3.
REQ-039 Scenario counter saturation: force zero_wr_cnt to 16'hFFFE, then apply 3 writes to r0 -> zero_wr_cnt=16'hFFFF and holds.
